// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter for the single-cycle datapath.
//   Holds the instruction address and updates it every rising CLK edge:
//   sequential step, relative branch, absolute jump, or return through a
//   circular return-address stack (RAS). i_stall freezes all state.
//
// Ports:
//   CLK, RST         clock; synchronous active-high reset
//   i_stall          hold PC, RAS, count and error this cycle
//   i_sel            00 SEQ, 01 BRANCH, 10 JUMP, 11 RETURN
//   i_take           branch condition (BRANCH only)
//   i_offset         signed byte offset for a taken BRANCH
//   i_target         absolute address for JUMP
//   i_call           push o_pc_plus on a taken BRANCH or a JUMP
//   o_pc             current PC (registered)
//   o_pc_plus        o_pc + STEP (combinational)
//   o_ras_count      number of valid RAS entries
//   o_ras_empty/full derived from o_ras_count
//   o_err            sticky: RETURN executed with an empty stack
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4,
    localparam int              CW           = $clog2(RAS_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_stall,
    input  logic [1:0]       i_sel,
    input  logic             i_take,
    input  logic [15:0]      i_offset,
    input  logic [WIDTH-1:0] i_target,
    input  logic             i_call,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus,
    output logic [CW-1:0]    o_ras_count,
    output logic             o_ras_empty,
    output logic             o_ras_full,
    output logic             o_err
);

    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_RET    = 2'b11
    } sel_e;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_tp;     // index of the most recent entry
    logic [CW-1:0]    r_cnt;
    logic             r_err;

    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_off;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_err_set;
    logic [PW-1:0]    w_tp_inc;
    logic             w_cnt_full;
    sel_e             w_sel;

    assign w_sel      = sel_e'(i_sel);
    assign w_pc_plus  = r_pc + WIDTH'(STEP);
    assign w_off      = WIDTH'($signed(i_offset));
    assign w_tp_inc   = r_tp + PW'(1);
    assign w_cnt_full = (r_cnt == CW'(RAS_DEPTH));

    always_comb begin
        w_pc_nxt  = w_pc_plus;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        case (w_sel)
            SEL_BRANCH: begin
                if (i_take) begin
                    w_pc_nxt = r_pc + w_off;
                    w_push   = i_call;
                end
            end
            SEL_JUMP: begin
                w_pc_nxt = i_target;
                w_push   = i_call;
            end
            SEL_RET: begin
                if (r_cnt != '0) begin
                    w_pc_nxt = r_ras[r_tp];
                    w_pop    = 1'b1;
                end else begin
                    w_err_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc  <= RESET_VECTOR;
            r_tp  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (!i_stall) begin
            r_pc  <= w_pc_nxt;
            r_err <= r_err | w_err_set;
            if (w_push) begin
                // Advancing the top pointer past a full stack lands on the
                // oldest entry, so overflow overwrites it naturally.
                r_tp <= w_tp_inc;
                if (!w_cnt_full)
                    r_cnt <= r_cnt + CW'(1);
            end else if (w_pop) begin
                r_tp  <= r_tp - PW'(1);
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Stack contents need no reset; the count alone qualifies them.
    always_ff @(posedge CLK) begin
        if (!RST && !i_stall && w_push)
            r_ras[w_tp_inc] <= w_pc_plus;
    end

    assign o_pc        = r_pc;
    assign o_pc_plus   = w_pc_plus;
    assign o_ras_count = r_cnt;
    assign o_ras_empty = (r_cnt == '0);
    assign o_ras_full  = w_cnt_full;
    assign o_err       = r_err;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int          W  = 32;
    localparam int          ST = 4;
    localparam logic [31:0] RV = 32'h100;
    localparam int          D  = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        i_stall = 1'b0;
    logic [1:0]  i_sel = 2'b00;
    logic        i_take = 1'b0;
    logic [15:0] i_offset = '0;
    logic [31:0] i_target = '0;
    logic        i_call = 1'b0;
    logic [31:0] o_pc, o_pc_plus;
    logic [2:0]  o_ras_count;
    logic        o_ras_empty, o_ras_full, o_err;

    int total = 0;
    int bad   = 0;

    // Reference model: PC, stack as a bounded queue (oldest at front), error.
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_err;

    always #5 CLK = ~CLK;

    pc_unit #(.WIDTH(W), .STEP(ST), .RESET_VECTOR(RV), .RAS_DEPTH(D)) dut (
        .CLK(CLK), .RST(RST), .i_stall(i_stall), .i_sel(i_sel), .i_take(i_take),
        .i_offset(i_offset), .i_target(i_target), .i_call(i_call),
        .o_pc(o_pc), .o_pc_plus(o_pc_plus), .o_ras_count(o_ras_count),
        .o_ras_empty(o_ras_empty), .o_ras_full(o_ras_full), .o_err(o_err)
    );

    // Drive one cycle of controls, advance the model, sample after the edge.
    task automatic cyc(input logic [1:0] sel, input logic take, input logic [15:0] off,
                       input logic [31:0] tgt, input logic call, input logic stall,
                       input logic rst);
        logic [31:0] plus;
        RST = rst; i_stall = stall; i_sel = sel; i_take = take;
        i_offset = off; i_target = tgt; i_call = call;
        plus = m_pc + ST;
        if (rst) begin
            m_pc = RV; m_stk.delete(); m_err = 1'b0;
        end else if (!stall) begin
            case (sel)
                2'b00: m_pc = plus;
                2'b01: begin
                    if (take) begin
                        m_pc = m_pc + 32'($signed(off));
                        if (call) m_stk.push_back(plus);
                    end else m_pc = plus;
                end
                2'b10: begin
                    m_pc = tgt;
                    if (call) m_stk.push_back(plus);
                end
                default: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_pc = plus; m_err = 1'b1; end
                end
            endcase
            if (m_stk.size() > D) void'(m_stk.pop_front());
        end
        @(posedge CLK); #1;
        RST = 1'b0; i_stall = 1'b0; i_call = 1'b0;
    endtask

    task automatic test_reset;
        cyc(2'b00, 0, 0, 0, 0, 0, 1);
        total++; if (o_pc !== 32'h100) begin bad++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 32'h100); end
        total++; if (o_ras_count !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", o_ras_count); end
        total++; if (o_ras_empty !== 1'b1 || o_ras_full !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=10", o_ras_empty, o_ras_full); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_err); end
    endtask

    task automatic test_seq;
        logic [31:0] exp;
        for (int i = 1; i <= 3; i++) begin
            cyc(2'b00, 0, 0, 0, 0, 0, 0);
            exp = 32'h100 + 32'(4 * i);
            total++; if (o_pc !== exp) begin bad++; $display("FAIL seq_pc got=%h exp=%h", o_pc, exp); end
            total++; if (o_pc_plus !== exp + 32'd4) begin bad++; $display("FAIL seq_plus got=%h exp=%h", o_pc_plus, exp + 32'd4); end
        end
        total++; if (o_ras_empty !== 1'b1) begin bad++; $display("FAIL seq_empty got=%b exp=1", o_ras_empty); end
    endtask

    task automatic test_branch;
        cyc(2'b01, 1, 16'hFFF8, 0, 0, 0, 0);
        total++; if (o_pc !== 32'h104) begin bad++; $display("FAIL br_taken got=%h exp=104", o_pc); end
        cyc(2'b00, 0, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0, 0);
        // untaken branch with call: falls through and must not push
        cyc(2'b01, 0, 16'hFFF8, 0, 1, 0, 0);
        total++; if (o_pc !== 32'h110) begin bad++; $display("FAIL br_untaken got=%h exp=110", o_pc); end
        total++; if (o_ras_count !== 3'd0) begin bad++; $display("FAIL br_untaken_cnt got=%0d exp=0", o_ras_count); end
        cyc(2'b10, 0, 0, 32'hFFFFFFFC, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0, 0);
        total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL seq_wrap got=%h exp=0", o_pc); end
        cyc(2'b01, 1, 16'hFFFC, 0, 0, 0, 0);
        total++; if (o_pc !== 32'hFFFFFFFC) begin bad++; $display("FAIL br_wrap got=%h exp=fffffffc", o_pc); end
    endtask

    task automatic test_call_return;
        cyc(2'b10, 0, 0, 32'h110, 0, 0, 0);
        cyc(2'b10, 0, 0, 32'h2000, 1, 0, 0);
        total++; if (o_pc !== 32'h2000 || o_ras_count !== 3'd1) begin bad++; $display("FAIL call got=%h/%0d exp=2000/1", o_pc, o_ras_count); end
        cyc(2'b11, 0, 0, 0, 0, 0, 0);
        total++; if (o_pc !== 32'h114 || o_ras_count !== 3'd0) begin bad++; $display("FAIL ret got=%h/%0d exp=114/0", o_pc, o_ras_count); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL ret_err got=%b exp=0", o_err); end
    endtask

    task automatic test_overflow;
        logic [31:0] exp;
        cyc(2'b10, 0, 0, 32'h3000, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            cyc(2'b10, 0, 0, 32'h3000 + 32'(i * 'h100), 1, 0, 0);
        total++; if (o_ras_count !== 3'd4 || o_ras_full !== 1'b1) begin bad++; $display("FAIL ovf_cnt got=%0d/%b exp=4/1", o_ras_count, o_ras_full); end
        // pushes were from 0x3000..0x3400; the oldest (0x3004) was overwritten
        for (int i = 4; i >= 1; i--) begin
            cyc(2'b11, 0, 0, 0, 0, 0, 0);
            exp = 32'h3000 + 32'(i * 'h100) + 32'd4;
            total++; if (o_pc !== exp) begin bad++; $display("FAIL ovf_ret got=%h exp=%h", o_pc, exp); end
        end
        total++; if (o_ras_empty !== 1'b1 || o_err !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%b/%b exp=1/0", o_ras_empty, o_err); end
        cyc(2'b11, 0, 0, 0, 0, 0, 0);
        total++; if (o_pc !== 32'h3108 || o_err !== 1'b1) begin bad++; $display("FAIL ret_empty got=%h/%b exp=3108/1", o_pc, o_err); end
        cyc(2'b00, 0, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0, 0);
        total++; if (o_pc !== 32'h3110 || o_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%h/%b exp=3110/1", o_pc, o_err); end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 3; i++) begin
            cyc(2'b10, 0, 0, 32'h5000, 1, 1, 0);
            total++; if (o_pc !== 32'h3110 || o_ras_count !== 3'd0 || o_err !== 1'b1) begin
                bad++; $display("FAIL stall_hold got=%h/%0d/%b exp=3110/0/1", o_pc, o_ras_count, o_err); end
        end
        cyc(2'b10, 0, 0, 32'h5000, 1, 0, 0);
        total++; if (o_pc !== 32'h5000 || o_ras_count !== 3'd1) begin bad++; $display("FAIL stall_release got=%h/%0d exp=5000/1", o_pc, o_ras_count); end
        cyc(2'b10, 0, 0, 32'h6000, 1, 0, 0);
        cyc(2'b01, 1, 16'h0040, 0, 1, 0, 0);
        total++; if (o_pc !== 32'h6040 || o_ras_count !== 3'd3) begin bad++; $display("FAIL br_call got=%h/%0d exp=6040/3", o_pc, o_ras_count); end
        cyc(2'b11, 0, 0, 0, 0, 1, 1);
        total++; if (o_pc !== 32'h100 || o_ras_count !== 3'd0 || o_err !== 1'b0) begin
            bad++; $display("FAIL rst_stall got=%h/%0d/%b exp=100/0/0", o_pc, o_ras_count, o_err); end
    endtask

    task automatic test_random;
        logic [1:0]  sel;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            sel = 2'($urandom_range(0, 3));
            tgt = (sel == 2'b10 && $urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : $urandom;
            cyc(sel, 1'($urandom), 16'($urandom), tgt, 1'($urandom),
                $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);
            total++; if (o_pc !== m_pc || o_pc_plus !== m_pc + 32'd4) begin
                bad++; $display("FAIL rnd_pc cyc=%0d got=%h/%h exp=%h", i, o_pc, o_pc_plus, m_pc); end
            total++; if (o_ras_count !== 3'(m_stk.size()) || o_ras_empty !== (m_stk.size() == 0) ||
                         o_ras_full !== (m_stk.size() == D) || o_err !== m_err) begin
                bad++; $display("FAIL rnd_state cyc=%0d got=%0d/%b/%b/%b exp=%0d/%b", i, o_ras_count,
                                o_ras_empty, o_ras_full, o_err, m_stk.size(), m_err); end
        end
    endtask

    initial begin
        m_pc = RV; m_err = 1'b0;
        test_reset;
        test_seq;
        test_branch;
        test_call_return;
        test_overflow;
        test_stall;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle datapath; successor of the fixed `PC` register. Holds the instruction address and advances it each `CLK` by a configurable step. Supports relative branches, absolute jumps, call/return through an internal circular return-address stack (RAS), and pipeline stall. Feeds the instruction memory address and the `PC+STEP` link value to the register file.

## Interface
- `WIDTH`, 32, address width in bits (≥ 8)
- `STEP`, 4, sequential increment in bytes (power of two)
- `RESET_VECTOR`, 0, `o_pc` value after reset
- `RAS_DEPTH`, 4, return-stack entries (power of two, ≥ 2)

Ports:
- `CLK`  in  1  clock, all state on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `i_stall`  in  1  hold all state this cycle
- `i_sel`  in  2  00 SEQ, 01 BRANCH, 10 JUMP, 11 RETURN
- `i_take`  in  1  branch condition (e.g. ALU `Zeroflag`); BRANCH only
- `i_offset`  in  16  signed byte offset for BRANCH
- `i_target`  in  WIDTH  absolute address for JUMP
- `i_call`  in  1  push link address on a taken BRANCH or JUMP
- `o_pc`  out  WIDTH  current PC, registered
- `o_pc_plus`  out  WIDTH  `o_pc + STEP`, combinational, mod 2^WIDTH
- `o_ras_count`  out  clog2(RAS_DEPTH+1)  valid RAS entries
- `o_ras_empty`  out  1  `o_ras_count == 0`
- `o_ras_full`  out  1  `o_ras_count == RAS_DEPTH`
- `o_err`  out  1  sticky: RETURN executed with empty stack

## Operation
- State: PC register; RAS array with top pointer `tp` (mod RAS_DEPTH) and saturating count; sticky `o_err`.
- Next PC when `i_stall=0`:
  - SEQ: `pc + STEP`.
  - BRANCH: `i_take=1` → `pc + sext(i_offset)`; else `pc + STEP`.
  - JUMP: `i_target`.
  - RETURN: stack non-empty → top entry; empty → `pc + STEP`, set `o_err`.
- All address arithmetic wraps mod 2^WIDTH; offset sign-extended to WIDTH. Low address bits used as given; no alignment check.
- Call: `i_call=1` with taken BRANCH or with JUMP pushes `o_pc_plus` (the pre-update value). `i_call` with SEQ, untaken BRANCH, or RETURN is ignored.
- Push when full: overwrite the oldest entry (circular); count stays at RAS_DEPTH; no error.
- Pop: returns the most recent entry, decrements count. After an overflow, at most RAS_DEPTH returns succeed, in LIFO order.
- `i_stall=1`: PC, RAS, count and `o_err` hold; all other inputs ignored.
- `o_err` clears only on `RST`.

## Timing
- Reset (synchronous, `RST=1` at rising edge): `o_pc=RESET_VECTOR`, `o_ras_count=0`, `o_ras_empty=1`, `o_ras_full=0`, `o_err=0`. RAS contents are don't-care.
- `RST` dominates `i_stall` and all other controls. Mid-sequence reset discards pending stack state.
- Latency 1: controls sampled at edge N; new `o_pc` visible after edge N. `o_pc_plus` follows `o_pc` combinationally in the same cycle.
- Push and pop complete in the same edge as the PC update. Flags are derived from the registered count, so they are valid the cycle after the edge.
- No simultaneous push and pop is possible: RETURN never pushes.

## Test plan
- Reset then 3 SEQ cycles, WIDTH=32, STEP=4, RESET_VECTOR=0x100 → `o_pc` 0x100, 0x104, 0x108, 0x10C; `o_ras_empty=1`.
- BRANCH `i_offset=-8`, `i_take=1` at pc=0x10C → 0x104. Same branch with `i_take=0` → 0x110. At pc=0xFFFFFFFC, SEQ → 0x0 (wrap).
- JUMP `i_target=0x2000`, `i_call=1` at pc=0x110 → pc=0x2000, count=1. Then RETURN → pc=0x114, count=0, `o_err=0`.
- Overflow: 5 calling JUMPs with RAS_DEPTH=4, from pcs A..E → count=4, full=1. Then 4 RETURNs → E+4, D+4, C+4, B+4. A 5th RETURN → pc+4, `o_err=1`, which stays set across later SEQ cycles.
- Stall: `i_stall=1` for 3 cycles during a JUMP with call → `o_pc` and count unchanged. Release → jump and push occur on the next edge.
- `RST` asserted with `i_stall=1` and count=3 → next cycle `o_pc=RESET_VECTOR`, count=0, `o_err=0`.
